// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types and helpers for the Wishbone round-robin arbiter.
// Revision : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

   // Largest master count the picker is written for
   localparam int unsigned MAX_NM = 8;

   // Arbiter ownership state
   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Index width that never collapses to zero bits
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_pick
// Purpose  : Combinational round-robin picker. Returns the first set request
//            at or after ptr, wrapping around NM entries.
// Revision : 1.0  initial release
// ============================================================================
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int unsigned NM = 2,
   parameter int unsigned PW = clog2_min1(NM)
) (
   input  logic [NM-1:0] req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          valid
);

   logic [2*NM-1:0]   dbl;
   logic [2*NM-1:0]   dbl_sh;
   logic [MAX_NM-1:0] rot_ext;
   int unsigned       offset;
   int unsigned       sum;

   // Rotate requests so ptr lands on bit 0, then take the lowest set bit
   always_comb begin
      dbl     = {req, req};
      dbl_sh  = dbl >> ptr;
      rot_ext = '0;
      rot_ext[NM-1:0] = dbl_sh[NM-1:0];
      offset  = 0;
      for (int i = MAX_NM - 1; i >= 0; i--) begin
         if (rot_ext[i]) offset = i;
      end
      sum = 32'(ptr) + offset;
      if (sum >= NM) sum = sum - NM;
      idx   = PW'(sum);
      valid = |req;
   end

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Round-robin arbiter sharing one pipelined Wishbone B4 slave port
//            between NM masters. Ownership lasts for a whole CYC envelope.
//            Optional macro WB_ARB_TIMEOUT_EN adds a no-response watchdog that
//            errors the owner and releases the bus after TIMEOUT cycles.
// Revision : 1.0  initial release
// ============================================================================
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter  int unsigned NM      = 2,
   parameter  int unsigned AW      = 32,
   parameter  int unsigned DW      = 32,
`ifdef WB_ARB_TIMEOUT_EN
   parameter  int unsigned TIMEOUT = 1024,
`endif
   localparam int unsigned GW      = clog2_min1(NM),
   localparam int unsigned SW      = DW / 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NM-1:0]    m_cyc,
   input  logic [NM-1:0]    m_stb,
   input  logic [NM-1:0]    m_we,
   input  logic [NM*AW-1:0] m_adr,
   input  logic [NM*SW-1:0] m_sel,
   input  logic [NM*DW-1:0] m_dat_w,
   output logic [DW-1:0]    m_dat_r,
   output logic [NM-1:0]    m_ack,
   output logic [NM-1:0]    m_err,
   output logic [NM-1:0]    m_stall,
   output logic             s_cyc,
   output logic             s_stb,
   output logic             s_we,
   output logic [AW-1:0]    s_adr,
   output logic [SW-1:0]    s_sel,
   output logic [DW-1:0]    s_dat_w,
   input  logic [DW-1:0]    s_dat_r,
   input  logic             s_ack,
   input  logic             s_err,
   input  logic             s_stall,
   output logic [GW-1:0]    grant,
   output logic             busy
);

   arb_state_e      state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]   pick_idx;
   logic            pick_valid;
   logic            tmo_active;   // cycle in which the forced error is presented
   logic            owner_live;

   wb_rr_pick #(.NM(NM), .PW(GW)) u_pick (
      .req   (m_cyc),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;

   // Watchdog: count BUSY cycles without a response, flag the expiry cycle
   always_comb begin
      cnt_d = cnt_q;
      to_d  = 1'b0;
      if (state_q == ARB_IDLE || s_ack || s_err) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      to_d = (state_q == ARB_BUSY) && !to_q && m_cyc[grant_q] &&
             !s_ack && !s_err && (cnt_q == CW'(TIMEOUT - 1));
   end

   // Watchdog registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign tmo_active = to_q;
`else
   assign tmo_active = 1'b0;
`endif

   // Ownership FSM: grant on any request, release when the owner drops CYC
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d  = ARB_BUSY;
               grant_d  = pick_idx;
               rr_ptr_d = (pick_idx == GW'(NM - 1)) ? '0 : pick_idx + 1'b1;
            end
         end
         ARB_BUSY: begin
            if (tmo_active || !m_cyc[grant_q]) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // FSM registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Bus mux: owner drives the slave, responses go back to the owner only
   always_comb begin
      owner_live = (state_q == ARB_BUSY) && !tmo_active;
      s_cyc      = 1'b0;
      s_stb      = 1'b0;
      s_we       = 1'b0;
      s_adr      = '0;
      s_sel      = '0;
      s_dat_w    = '0;
      m_ack      = '0;
      m_err      = '0;
      m_stall    = '1;
      if (owner_live) begin
         s_cyc   = m_cyc[grant_q];
         s_stb   = m_stb[grant_q];
         s_we    = m_we[grant_q];
         s_adr   = m_adr[grant_q*AW +: AW];
         s_sel   = m_sel[grant_q*SW +: SW];
         s_dat_w = m_dat_w[grant_q*DW +: DW];
         // Responses arriving after the owner drops CYC are discarded
         m_ack[grant_q]   = s_ack & m_cyc[grant_q];
         m_err[grant_q]   = s_err & m_cyc[grant_q];
         m_stall[grant_q] = s_stall;
      end
      if (tmo_active) m_err[grant_q] = 1'b1;
   end

   assign m_dat_r = s_dat_r;
   assign grant   = grant_q;
   assign busy    = (state_q == ARB_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rr_arbiter
// Purpose  : Directed self-checking bench for wb_rr_arbiter (NM=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_rr_arbiter;

   localparam int NM = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM-1:0]    m_cyc, m_stb, m_we;
   logic [NM*AW-1:0] m_adr;
   logic [NM*SW-1:0] m_sel;
   logic [NM*DW-1:0] m_dat_w;
   logic [DW-1:0]    m_dat_r;
   logic [NM-1:0]    m_ack, m_err, m_stall;
   logic             s_cyc, s_stb, s_we;
   logic [AW-1:0]    s_adr;
   logic [SW-1:0]    s_sel;
   logic [DW-1:0]    s_dat_w;
   logic [DW-1:0]    s_dat_r;
   logic             s_ack, s_err, s_stall;
   logic [1:0]       grant;
   logic             busy;

   int n_tests = 0;
   int n_fail  = 0;

   wb_rr_arbiter #(
      .NM(NM), .AW(AW), .DW(DW)
`ifdef WB_ARB_TIMEOUT_EN
      , .TIMEOUT(16)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
      .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
      .m_stall(m_stall),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
      .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
      .s_stall(s_stall),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      m_cyc   = '0;
      m_stb   = '0;
      m_we    = '0;
      m_sel   = '1;
      m_adr   = '0;
      m_dat_w = '0;
      s_dat_r = '0;
      s_ack   = 1'b0;
      s_err   = 1'b0;
      s_stall = 1'b0;
      for (int i = 0; i < NM; i++) begin
         m_adr[i*AW +: AW]   = 32'h100 * (i + 1);
         m_dat_w[i*DW +: DW] = 32'hA000_0000 + i;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      s_ack = 1'b1;
      step();
      settle();
      n_tests++;
      if (busy !== 1'b0 || grant !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b grant=%0d, required busy=0 grant=0", busy, grant);
      end
      n_tests++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_slave: s_cyc=%b s_stb=%b s_adr=%h, required 0 0 0", s_cyc, s_stb, s_adr);
      end
      n_tests++;
      if (m_stall !== 4'hF || m_ack !== 4'h0 || m_err !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_master: stall=%b ack=%b err=%b, required 1111 0000 0000", m_stall, m_ack, m_err);
      end
      s_ack = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_single_master();
      do_reset();
      m_cyc = 4'b0001;
      m_stb = 4'b0001;
      settle();
      n_tests++;
      if (busy !== 1'b0 || m_stall !== 4'hF) begin
         n_fail++;
         $display("FAIL single_latency: busy=%b stall=%b, required busy=0 stall=1111", busy, m_stall);
      end
      step();
      settle();
      n_tests++;
      if (busy !== 1'b1 || grant !== 2'd0 || s_cyc !== 1'b1 || s_stb !== 1'b1 ||
          s_adr !== 32'h100 || m_stall !== 4'b1110) begin
         n_fail++;
         $display("FAIL single_grant: busy=%b grant=%0d s_cyc=%b s_stb=%b adr=%h stall=%b, required 1 0 1 1 00000100 1110",
                  busy, grant, s_cyc, s_stb, s_adr, m_stall);
      end
      s_ack   = 1'b1;
      s_dat_r = 32'hDEAD_BEEF;
      settle();
      n_tests++;
      if (m_ack !== 4'b0001 || m_dat_r !== 32'hDEAD_BEEF || m_err !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_read: ack=%b dat=%h err=%b, required 0001 deadbeef 0000", m_ack, m_dat_r, m_err);
      end
      step();
      s_ack = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      step();
      settle();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_contention();
      do_reset();
      m_cyc = 4'b0011;
      m_stb = 4'b0011;
      step();
      settle();
      n_tests++;
      if (busy !== 1'b1 || grant !== 2'd0 || m_stall !== 4'b1110 || s_adr !== 32'h100) begin
         n_fail++;
         $display("FAIL contention_first: busy=%b grant=%0d stall=%b adr=%h, required 1 0 1110 00000100",
                  busy, grant, m_stall, s_adr);
      end
      step();
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      step();
      settle();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL contention_gap: busy=%b, required 0", busy);
      end
      step();
      settle();
      n_tests++;
      if (busy !== 1'b1 || grant !== 2'd1 || s_adr !== 32'h200 || m_stall !== 4'b1101) begin
         n_fail++;
         $display("FAIL contention_second: busy=%b grant=%0d adr=%h stall=%b, required 1 1 00000200 1101",
                  busy, grant, s_adr, m_stall);
      end
      m_cyc = '0;
      m_stb = '0;
      step();
      step();
   endtask

   task automatic test_rotation();
      logic [1:0] exp_g;
      logic [3:0] onehot;
      do_reset();
      m_cyc = 4'hF;
      m_stb = 4'hF;
      step();
      settle();
      for (int k = 0; k < 5; k++) begin
         int w;
         w = 0;
         while (!busy && w < 10) begin
            step();
            settle();
            w++;
         end
         exp_g  = 2'(k % 4);
         onehot = 4'b0001 << exp_g;
         n_tests++;
         if (busy !== 1'b1 || grant !== exp_g || m_stall !== ~onehot) begin
            n_fail++;
            $display("FAIL rotation_grant[%0d]: busy=%b grant=%0d stall=%b, required 1 %0d %b",
                     k, busy, grant, m_stall, exp_g, ~onehot);
         end
         s_ack = 1'b1;
         settle();
         n_tests++;
         if (m_ack !== onehot) begin
            n_fail++;
            $display("FAIL rotation_ack[%0d]: ack=%b, required %b", k, m_ack, onehot);
         end
         step();
         s_ack = 1'b0;
         m_cyc[exp_g] = 1'b0;
         m_stb[exp_g] = 1'b0;
         step();
         m_cyc[exp_g] = 1'b1;
         m_stb[exp_g] = 1'b1;
         step();
         settle();
      end
      m_cyc = '0;
      m_stb = '0;
      step();
      step();
   endtask

   task automatic test_burst();
      logic [7:0] pat;
      int issued, accepts, acks_own, acks_other;
      logic pend, acc;
      pat = 8'b0101_1010;
      issued = 0; accepts = 0; acks_own = 0; acks_other = 0; pend = 1'b0;
      do_reset();
      m_cyc = 4'b1100;
      m_stb = 4'b1100;
      step();
      settle();
      n_tests++;
      if (busy !== 1'b1 || grant !== 2'd2) begin
         n_fail++;
         $display("FAIL burst_grant: busy=%b grant=%0d, required 1 2", busy, grant);
      end
      for (int c = 0; c < 30 && acks_own < 4; c++) begin
         s_stall  = pat[c % 8];
         m_stb[2] = (issued < 4);
         s_ack    = pend;
         settle();
         acc = s_cyc && s_stb && !s_stall;
         if (acc) begin
            accepts++;
            issued++;
         end
         if (m_ack[2]) acks_own++;
         if ((m_ack & 4'b1011) != 4'b0000) acks_other++;
         pend = acc;
         step();
      end
      s_ack   = 1'b0;
      s_stall = 1'b0;
      n_tests++;
      if (accepts !== 4 || acks_own !== 4 || acks_other !== 0) begin
         n_fail++;
         $display("FAIL burst_counts: accepts=%0d owner_acks=%0d other_acks=%0d, required 4 4 0",
                  accepts, acks_own, acks_other);
      end
      m_cyc = '0;
      m_stb = '0;
      step();
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_cyc = 4'b0011;
      m_stb = 4'b0011;
      step();
      step();
      step();
      settle();
      rst   = 1'b1;
      s_ack = 1'b1;
      step();
      settle();
      n_tests++;
      if (busy !== 1'b0 || s_cyc !== 1'b0 || m_stall !== 4'hF || m_ack !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b s_cyc=%b stall=%b ack=%b, required 0 0 1111 0000",
                  busy, s_cyc, m_stall, m_ack);
      end
      rst   = 1'b0;
      s_ack = 1'b0;
      step();
      settle();
      n_tests++;
      if (busy !== 1'b1 || grant !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid_ptr: busy=%b grant=%0d, required 1 0", busy, grant);
      end
      m_cyc = '0;
      m_stb = '0;
      step();
      step();
   endtask

   task automatic test_hung_slave();
      int err_cnt, err_at;
      err_cnt = 0;
      err_at  = -1;
      do_reset();
      m_cyc = 4'b0011;
      m_stb = 4'b0011;
      step();
      settle();
`ifdef WB_ARB_TIMEOUT_EN
      for (int idx = 0; idx <= 16; idx++) begin
         if (m_err !== 4'b0000) begin
            err_cnt++;
            err_at = idx;
            n_tests++;
            if (m_err !== 4'b0001 || s_cyc !== 1'b0) begin
               n_fail++;
               $display("FAIL timeout_pulse: err=%b s_cyc=%b, required 0001 0", m_err, s_cyc);
            end
         end
         step();
         settle();
      end
      n_tests++;
      if (err_cnt !== 1 || err_at !== 16 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_once: count=%0d at=%0d busy=%b, required 1 16 0", err_cnt, err_at, busy);
      end
      step();
      settle();
      n_tests++;
      if (busy !== 1'b1 || grant !== 2'd1) begin
         n_fail++;
         $display("FAIL timeout_next: busy=%b grant=%0d, required 1 1", busy, grant);
      end
`else
      for (int idx = 0; idx < 40; idx++) begin
         if (m_err !== 4'b0000) err_cnt++;
         step();
         settle();
      end
      n_tests++;
      if (busy !== 1'b1 || grant !== 2'd0 || err_cnt !== 0) begin
         n_fail++;
         $display("FAIL hung_hold: busy=%b grant=%0d errs=%0d, required 1 0 0", busy, grant, err_cnt);
      end
`endif
      m_cyc = '0;
      m_stb = '0;
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_master();
      test_contention();
      test_rotation();
      test_burst();
      test_reset_mid();
      test_hung_slave();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
